// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS control path
// (state numbering, opcode/funct values, ALUop and mux select codes).
package mc_pkg;

   typedef enum logic [2:0] {
      ST_IF  = 3'd0,
      ST_ID  = 3'd1,
      ST_EX  = 3'd2,
      ST_MEM = 3'd3,
      ST_WB  = 3'd4
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h21;
   localparam logic [5:0] FN_SUB = 6'h23;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// alu_dec: R-type funct to ALUop decode; unsupported funct yields ADD with
// legal=0 so the control FSM can turn the instruction into a NOP.
module alu_dec
   import mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_op,
   output logic       legal
);

   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b1;
      case (funct)
         FN_ADD:  alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_SLT:  alu_op = ALU_SLT;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main control FSM (IF/ID/EX/MEM/WB) with memory stalls.
// Define MC_CTRL_PERF_EN to add the cycle_cnt / inst_cnt performance counters.
module mc_ctrl
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [2:0]  alu_op,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        i_or_d,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] inst_cnt
`endif
);

   state_e     state_q, state_d;
   logic [2:0] rtype_alu_op;
   logic       rtype_legal;
   logic       is_rtype, is_addiu, is_lw, is_sw, is_beq, is_bne, is_j;

   alu_dec u_alu_dec (
      .funct  (funct),
      .alu_op (rtype_alu_op),
      .legal  (rtype_legal)
   );

   // Anything not matched here falls through EX as a NOP.
   always_comb begin
      is_rtype = (opcode == OP_RTYPE) && rtype_legal;
      is_addiu = (opcode == OP_ADDIU);
      is_lw    = (opcode == OP_LW);
      is_sw    = (opcode == OP_SW);
      is_beq   = (opcode == OP_BEQ);
      is_bne   = (opcode == OP_BNE);
      is_j     = (opcode == OP_J);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IF;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IF:  if (mem_ready) state_d = ST_ID;
         ST_ID:  state_d = ST_EX;
         ST_EX: begin
            if (is_rtype || is_addiu) state_d = ST_WB;
            else if (is_lw || is_sw)  state_d = ST_MEM;
            else                      state_d = ST_IF;
         end
         ST_MEM: if (mem_ready) state_d = is_lw ? ST_WB : ST_IF;
         ST_WB:  state_d = ST_IF;
         default: state_d = ST_IF;
      endcase
   end

   always_comb begin
      alu_op     = 3'b000;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      pc_write   = 1'b0;
      pc_src     = PCSRC_ALU;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      case (state_q)
         ST_IF: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_op    = ALU_ADD;
            // Gated by resetn so no write enable leaks out while reset is held.
            ir_write  = mem_ready & resetn;
            pc_write  = mem_ready & resetn;
         end
         ST_ID: begin
            alu_src_b = SRCB_IMM_SH2;
            alu_op    = ALU_ADD;
         end
         ST_EX: begin
            if (is_rtype) begin
               alu_src_a = 1'b1;
               alu_op    = rtype_alu_op;
            end else if (is_addiu || is_lw || is_sw) begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               alu_op    = ALU_ADD;
            end else if (is_beq || is_bne) begin
               alu_src_a = 1'b1;
               alu_op    = ALU_SUB;
               pc_src    = PCSRC_ALUOUT;
               pc_write  = is_beq ? zero : ~zero;
            end else if (is_j) begin
               pc_write  = 1'b1;
               pc_src    = PCSRC_JUMP;
            end
         end
         ST_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = is_lw;
            mem_write = is_sw;
         end
         ST_WB: begin
            reg_write  = 1'b1;
            reg_dst    = is_rtype;
            mem_to_reg = is_lw;
         end
         default: ;
      endcase
   end

   assign state = state_q;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] inst_cnt_q, inst_cnt_d;

   // An instruction retires on any return to IF from EX, MEM or WB.
   always_comb begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      inst_cnt_d  = inst_cnt_q;
      if ((state_d == ST_IF) &&
          ((state_q == ST_EX) || (state_q == ST_MEM) || (state_q == ST_WB)))
         inst_cnt_d = inst_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cycle_cnt_q <= 32'd0;
         inst_cnt_q  <= 32'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         inst_cnt_q  <= inst_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign inst_cnt  = inst_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized instruction stream for mc_ctrl, checked
// cycle by cycle against a phase-list reference model of the control rules.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [2:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       ir_write, mem_read, mem_write, i_or_d;
   logic       reg_write, reg_dst, mem_to_reg;
   logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt, inst_cnt;
`endif

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .alu_op     (alu_op),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .ir_write   (ir_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .i_or_d     (i_or_d),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .state      (state)
`ifdef MC_CTRL_PERF_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .inst_cnt   (inst_cnt)
`endif
   );

   localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4;
   localparam int C_R = 0, C_ADDIU = 1, C_LW = 2, C_SW = 3, C_BEQ = 4,
                  C_BNE = 5, C_J = 6, C_NOP = 7;

   int checks = 0;
   int errors = 0;
   int cyc_m  = 0;
   int inst_m = 0;

   logic [18:0] obs;
   assign obs = {state, alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
                 mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg};

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00:   return (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 ||
                          fn == 6'h25 || fn == 6'h2A) ? C_R : C_NOP;
         6'h09:   return C_ADDIU;
         6'h23:   return C_LW;
         6'h2B:   return C_SW;
         6'h04:   return C_BEQ;
         6'h05:   return C_BNE;
         6'h02:   return C_J;
         default: return C_NOP;
      endcase
   endfunction

   function automatic logic [2:0] r_aluop(input logic [5:0] fn);
      case (fn)
         6'h23:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2A:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic [18:0] pack(
      input logic [2:0] st, input logic [2:0] aop, input logic sa, input logic [1:0] sb,
      input logic pw, input logic [1:0] ps, input logic iw, input logic mr,
      input logic mw, input logic iod, input logic rw, input logic rd, input logic m2r);
      return {st, aop, sa, sb, pw, ps, iw, mr, mw, iod, rw, rd, m2r};
   endfunction

   function automatic logic [18:0] expect_out(input int cls, input int ph,
                                              input logic [5:0] fn,
                                              input logic z, input logic rdy);
      case (ph)
         P_IF: return pack(3'd0, 3'b010, 1'b0, 2'b01, rdy, 2'b00, rdy,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         P_ID: return pack(3'd1, 3'b010, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         P_EX: begin
            case (cls)
               C_R:   return pack(3'd2, r_aluop(fn), 1'b1, 2'b00, 1'b0, 2'b00, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               C_ADDIU, C_LW, C_SW:
                      return pack(3'd2, 3'b010, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               C_BEQ: return pack(3'd2, 3'b110, 1'b1, 2'b00, z, 2'b01, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               C_BNE: return pack(3'd2, 3'b110, 1'b1, 2'b00, ~z, 2'b01, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               C_J:   return pack(3'd2, 3'b000, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               default: return pack(3'd2, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
         end
         P_MEM: return pack(3'd3, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0,
                            cls == C_LW, cls == C_SW, 1'b1, 1'b0, 1'b0, 1'b0);
         default: return pack(3'd4, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, cls == C_R, cls == C_LW);
      endcase
   endfunction

   task automatic check_out(input string tag, input logic [18:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_cnt(input string tag);
`ifdef MC_CTRL_PERF_EN
      checks++;
      assert (cycle_cnt === 32'(cyc_m)) else begin
         errors++;
         $error("FAIL %s cycle_cnt observed=%0d expected=%0d", tag, cycle_cnt, cyc_m);
      end
      checks++;
      assert (inst_cnt === 32'(inst_m)) else begin
         errors++;
         $error("FAIL %s inst_cnt observed=%0d expected=%0d", tag, inst_cnt, inst_m);
      end
`else
      if (tag.len() < 0) checks++;
`endif
   endtask

   // Reset asserted mid-cycle with mem_ready high: fetch request visible, no writes.
   task automatic do_reset();
      mem_ready = 1'b1;
      opcode    = 6'($urandom);
      resetn    = 1'b0;
      cyc_m     = 0;
      inst_m    = 0;
      #1;
      check_out("reset_async", expect_out(C_NOP, P_IF, 6'h00, 1'b0, 1'b0));
      check_cnt("reset_async");
      @(posedge clk);
      #1;
      check_out("reset_held", expect_out(C_NOP, P_IF, 6'h00, 1'b0, 1'b0));
      check_cnt("reset_held");
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z_ex,
                            input int wait_if, input int wait_mem, input bit abort_ex);
      int   cls;
      int   ph_q[$];
      bit   rdy_q[$];
      cls = classify(op, fn);
      for (int k = 0; k <= wait_if; k++) begin
         ph_q.push_back(P_IF);
         rdy_q.push_back(k == wait_if);
      end
      ph_q.push_back(P_ID); rdy_q.push_back(1'($urandom));
      ph_q.push_back(P_EX); rdy_q.push_back(1'($urandom));
      if (cls == C_LW || cls == C_SW)
         for (int k = 0; k <= wait_mem; k++) begin
            ph_q.push_back(P_MEM);
            rdy_q.push_back(k == wait_mem);
         end
      if (cls == C_R || cls == C_ADDIU || cls == C_LW) begin
         ph_q.push_back(P_WB); rdy_q.push_back(1'($urandom));
      end
      for (int i = 0; i < ph_q.size(); i++) begin
         @(negedge clk);
         resetn    = 1'b1;
         opcode    = op;
         funct     = fn;
         zero      = (ph_q[i] == P_EX) ? z_ex : 1'($urandom);
         mem_ready = rdy_q[i];
         #1;
         check_out($sformatf("op%02h_fn%02h_ph%0d_c%0d", op, fn, ph_q[i], i),
                   expect_out(cls, ph_q[i], fn, zero, mem_ready));
         check_cnt($sformatf("cnt_op%02h_c%0d", op, i));
         if (abort_ex && ph_q[i] == P_EX) begin
            #1;
            resetn = 1'b0;
            cyc_m  = 0;
            inst_m = 0;
            #1;
            check_out("abort_reset", expect_out(C_NOP, P_IF, 6'h00, 1'b0, 1'b0));
            check_cnt("abort_reset");
            return;
         end
         cyc_m++;
         if (i == ph_q.size() - 1) inst_m++;
      end
   endtask

   initial begin
      logic [5:0] op_tab [8];
      logic [5:0] fn_tab [6];
      op_tab = '{6'h00, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
      fn_tab = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00};
      #2;
      do_reset();
      run_instr(6'h00, 6'h23, 1'b0, 0, 0, 0);   // SUB, zero wait
      run_instr(6'h23, 6'h11, 1'b0, 0, 3, 0);   // lw, 3 wait cycles in MEM
      run_instr(6'h04, 6'h00, 1'b1, 0, 0, 0);   // beq taken
      run_instr(6'h04, 6'h00, 1'b0, 0, 0, 0);   // beq not taken
      run_instr(6'h05, 6'h00, 1'b1, 0, 0, 0);   // bne not taken
      run_instr(6'h05, 6'h00, 1'b0, 0, 0, 0);   // bne taken
      run_instr(6'h3F, 6'h21, 1'b1, 0, 0, 0);   // illegal opcode
      run_instr(6'h00, 6'h3F, 1'b0, 1, 0, 0);   // illegal funct
      run_instr(6'h2B, 6'h00, 1'b0, 2, 1, 0);   // sw with waits
      run_instr(6'h09, 6'h00, 1'b0, 0, 0, 0);   // addiu
      run_instr(6'h02, 6'h00, 1'b0, 1, 0, 0);   // j
      run_instr(6'h00, 6'h2A, 1'b0, 0, 0, 0);   // SLT

      do_reset();
      for (int n = 0; n < 10; n++)
         run_instr(6'h00, fn_tab[n % 5], 1'b0, 0, 0, 0);
`ifdef MC_CTRL_PERF_EN
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      assert (cycle_cnt === 32'd40 && inst_cnt === 32'd10) else begin
         errors++;
         $error("FAIL perf_10_rtype observed=%0d/%0d expected=40/10", cycle_cnt, inst_cnt);
      end
      cyc_m++;
`endif
      run_instr(6'h00, 6'h21, 1'b0, 0, 0, 1);   // reset mid-EX
      run_instr(6'h23, 6'h00, 1'b0, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         logic [5:0] op, fn;
         op = op_tab[$urandom_range(0, 7)];
         fn = fn_tab[$urandom_range(0, 5)];
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
